// File: rtl/sva_tb_pkg.sv
// Shared FSM encoding and default parameters for the SVA stimulus generator
// and its clock divider.
package sva_tb_pkg;

   localparam int unsigned DEF_CLK_DIV     = 4;
   localparam int unsigned DEF_PAT_LEN     = 16;
   localparam int unsigned DEF_CHK_LAT     = 2;
   localparam int unsigned DEF_RST_PERIODS = 2;
   localparam int unsigned DEF_CNT_WIDTH   = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRST  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } stim_fsm_t;

endpackage

// File: rtl/gclk_div.sv
// Free-running user-clock divider: gclk toggles every CLK_DIV sys_clk cycles,
// with one-cycle strobes in the cycle gclk is about to rise or fall.
module gclk_div
   import sva_tb_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic gclk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int unsigned DW = $clog2(CLK_DIV);

   logic [DW-1:0] cnt_q, cnt_d;
   logic          gclk_q;
   logic          wrap;

   always_comb begin
      wrap  = (cnt_q == DW'(CLK_DIV - 1));
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   // NOTE: sequential state is assigned with <= only, so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q  <= '0;
         gclk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (wrap) gclk_q <= ~gclk_q;
      end
   end

   assign gclk      = gclk_q;
   assign rise_tick = wrap & ~gclk_q;
   assign fall_tick = wrap &  gclk_q;

endmodule

// File: rtl/sva_stim_gen.sv
// Drives a/b stimulus into an SVA checker on a divided clock, counts its
// succ/fail verdicts and flags any disagreement with the expected counts.
module sva_stim_gen
   import sva_tb_pkg::*;
#(
   parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
   parameter int unsigned PAT_LEN     = DEF_PAT_LEN,
   parameter int unsigned CHK_LAT     = DEF_CHK_LAT,   // must be >= 1
   parameter int unsigned RST_PERIODS = DEF_RST_PERIODS,
   parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic [PAT_LEN-1:0]   pat_a,
   input  logic [PAT_LEN-1:0]   pat_b,
   output logic                 gclk,
   output logic                 grst,
   output logic                 a,
   output logic                 b,
   input  logic                 succ,
   input  logic                 fail,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] succ_cnt,
   output logic [CNT_WIDTH-1:0] fail_cnt,
   output logic [CNT_WIDTH-1:0] exp_succ,
   output logic                 err
);

   localparam int unsigned TW        = $clog2(PAT_LEN + CHK_LAT + 1);
   localparam int unsigned RW        = $clog2(RST_PERIODS + 1);
   localparam int unsigned LAST_TICK = PAT_LEN + CHK_LAT - 1;

   logic rise_tick, fall_tick;

   gclk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .gclk      (gclk),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   stim_fsm_t            state_q, state_d;
   logic [PAT_LEN-1:0]   pat_a_q, pat_a_d, pat_b_q, pat_b_d;
   logic                 a_q, a_d, b_q, b_d, grst_q, grst_d, err_q, err_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0] succ_cnt_q, succ_cnt_d, fail_cnt_q, fail_cnt_d;
   logic [CNT_WIDTH-1:0] exp_q, exp_d;
   logic                 sample, mismatch;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // NOTE: every variable gets its default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pat_a_d    = pat_a_q;
      pat_b_d    = pat_b_q;
      a_d        = a_q;
      b_d        = b_q;
      grst_d     = grst_q;
      err_d      = err_q;
      tick_d     = tick_q;
      rst_cnt_d  = rst_cnt_q;
      succ_cnt_d = succ_cnt_q;
      fail_cnt_d = fail_cnt_q;
      exp_d      = exp_q;

      mismatch = (succ_cnt_q != exp_q) ||
                 (fail_cnt_q != CNT_WIDTH'(PAT_LEN) - exp_q);

      // tick_q counts fall ticks since the first pattern drive
      sample = fall_tick && (state_q == ST_RUN || state_q == ST_DRAIN) &&
               (tick_q >= TW'(CHK_LAT));
      if (sample) begin
         if (succ)         succ_cnt_d = sat_inc(succ_cnt_q);
         if (fail)         fail_cnt_d = sat_inc(fail_cnt_q);
         if (succ == fail) err_d      = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (fall_tick) grst_d = 1'b0;
            if (start) begin
               pat_a_d    = pat_a;
               pat_b_d    = pat_b;
               succ_cnt_d = '0;
               fail_cnt_d = '0;
               exp_d      = '0;
               err_d      = 1'b0;
               grst_d     = 1'b1;
               rst_cnt_d  = '0;
               state_d    = ST_GRST;
            end
         end
         ST_GRST: begin
            if (rise_tick && rst_cnt_q != RW'(RST_PERIODS))
               rst_cnt_d = rst_cnt_q + 1'b1;
            if (fall_tick && rst_cnt_q == RW'(RST_PERIODS)) begin
               grst_d  = 1'b0;
               tick_d  = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (fall_tick) begin
               a_d     = pat_a_q[0];
               b_d     = pat_b_q[0];
               pat_a_d = pat_a_q >> 1;
               pat_b_d = pat_b_q >> 1;
               if (pat_a_q[0] & pat_b_q[0]) exp_d = sat_inc(exp_q);
               tick_d  = tick_q + 1'b1;
               if (tick_q == TW'(PAT_LEN - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fall_tick) begin
               a_d    = 1'b0;
               b_d    = 1'b0;
               tick_d = tick_q + 1'b1;
               if (tick_q == TW'(LAST_TICK)) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            err_d   = err_q | mismatch;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         pat_a_q    <= '0;
         pat_b_q    <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         grst_q     <= 1'b1;
         err_q      <= 1'b0;
         tick_q     <= '0;
         rst_cnt_q  <= '0;
         succ_cnt_q <= '0;
         fail_cnt_q <= '0;
         exp_q      <= '0;
      end else begin
         state_q    <= state_d;
         pat_a_q    <= pat_a_d;
         pat_b_q    <= pat_b_d;
         a_q        <= a_d;
         b_q        <= b_d;
         grst_q     <= grst_d;
         err_q      <= err_d;
         tick_q     <= tick_d;
         rst_cnt_q  <= rst_cnt_d;
         succ_cnt_q <= succ_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         exp_q      <= exp_d;
      end
   end

   // err already includes the final count comparison while done is high
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      err      = err_q | (done & mismatch);
      grst     = grst_q;
      a        = a_q;
      b        = b_q;
      succ_cnt = succ_cnt_q;
      fail_cnt = fail_cnt_q;
      exp_succ = exp_q;
   end

endmodule
